// File: rtl/line_sensor_conditioner_pkg.sv
// rtl/line_sensor_conditioner_pkg.sv - steering encodings and FSM states for the line follower
package line_sensor_conditioner_pkg;

    // Output encodings shared with the PID controller and servo handler
    localparam logic [1:0] FOLLOW_REST  = 2'b00;
    localparam logic [1:0] FOLLOW_LEFT  = 2'b01;
    localparam logic [1:0] FOLLOW_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_REST,
        ST_TURN_L,
        ST_TURN_R,
        ST_CROSS
    } steer_state_t;

    // Debounced pair is {right, left}
    function automatic steer_state_t decode_pair(input logic [1:0] pair);
        steer_state_t st;
        case (pair)
            2'b00:   st = ST_REST;
            2'b01:   st = ST_TURN_L;
            2'b10:   st = ST_TURN_R;
            default: st = ST_CROSS;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - single-bit 2-flop synchroniser plus level debounce
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= sensor;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level has differed for DEBOUNCE_CYCLES samples in a row
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/line_sensor_conditioner.sv
// rtl/line_sensor_conditioner.sv - debounced IR line sensors and registered steering decision
module line_sensor_conditioner
    import line_sensor_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int LOST_TIMEOUT    = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sensor,
    output logic [1:0] sensors_signal,
    output logic [1:0] follower_state,
    output logic       state_change,
    output logic       line_lost
);

    localparam int TW = $clog2(LOST_TIMEOUT);
    localparam logic [TW-1:0] LOST_LAST = TW'(LOST_TIMEOUT - 1);

    steer_state_t  state;
    steer_state_t  next_state;
    logic [TW-1:0] lost_cnt;
    logic [TW-1:0] lost_cnt_next;
    logic          line_lost_next;
    logic [1:0]    follower_next;
    logic [1:0]    last_out;
    logic [1:0]    last_out_next;

    for (genvar i = 0; i < 2; i++) begin : g_bit
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .sensor(sensor[i]),
            .level (sensors_signal[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_REST;
            lost_cnt       <= '0;
            line_lost      <= 1'b0;
            follower_state <= FOLLOW_REST;
            last_out       <= FOLLOW_REST;
            state_change   <= 1'b0;
        end else begin
            state          <= next_state;
            lost_cnt       <= lost_cnt_next;
            line_lost      <= line_lost_next;
            follower_state <= follower_next;
            last_out       <= last_out_next;
            state_change   <= (follower_next != follower_state);
        end
    end

    always_comb begin
        next_state     = decode_pair(sensors_signal);
        lost_cnt_next  = '0;
        line_lost_next = 1'b0;
        follower_next  = FOLLOW_REST;
        last_out_next  = last_out;

        // Timer runs only while CROSS persists; saturates once expired
        if (state == ST_CROSS && next_state == ST_CROSS) begin
            if (lost_cnt == LOST_LAST) begin
                lost_cnt_next  = lost_cnt;
                line_lost_next = 1'b1;
            end else begin
                lost_cnt_next = lost_cnt + TW'(1);
            end
        end

        case (next_state)
            ST_REST:   follower_next = FOLLOW_REST;
            ST_TURN_L: follower_next = FOLLOW_LEFT;
            ST_TURN_R: follower_next = FOLLOW_RIGHT;
            default:   follower_next = line_lost_next ? FOLLOW_REST : last_out;
        endcase

        if (next_state != ST_CROSS) begin
            last_out_next = follower_next;
        end
    end

endmodule

// File: tb/tb_line_sensor_conditioner.sv
// tb/tb_line_sensor_conditioner.sv - randomized and directed bench with behavioural reference model
module tb_line_sensor_conditioner;

    localparam int DB = 4;
    localparam int LT = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sensor = 2'b00;
    logic [1:0] sensors_signal;
    logic [1:0] follower_state;
    logic       state_change;
    logic       line_lost;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [1:0] hist[$];
    logic [1:0] m_ss = 2'b00;
    logic [1:0] m_fs = 2'b00;
    logic       m_sc = 1'b0;
    logic       m_lost = 1'b0;
    logic [1:0] m_last = 2'b00;
    bit         m_in_cross = 1'b0;
    int         m_age = 0;

    always #5 clk = ~clk;

    line_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .LOST_TIMEOUT   (LT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sensor        (sensor),
        .sensors_signal(sensors_signal),
        .follower_state(follower_state),
        .state_change  (state_change),
        .line_lost     (line_lost)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the pad value and reset seen at that edge
    task automatic model_edge();
        logic [1:0] old_fs;
        bit         all_diff;
        int         idx;
        logic       v;
        if (rst) begin
            hist.delete();
            m_ss = 2'b00; m_fs = 2'b00; m_sc = 1'b0; m_lost = 1'b0;
            m_last = 2'b00; m_in_cross = 1'b0; m_age = 0;
            return;
        end
        hist.push_back(sensor);
        old_fs = m_fs;
        if (m_ss == 2'b11) begin
            m_age      = m_in_cross ? m_age + 1 : 0;
            m_in_cross = 1'b1;
            m_lost     = (m_age >= LT);
            m_fs       = m_lost ? 2'b00 : m_last;
        end else begin
            m_in_cross = 1'b0;
            m_age      = 0;
            m_lost     = 1'b0;
            m_fs       = (m_ss == 2'b00) ? 2'b00 : (m_ss == 2'b01) ? 2'b01 : 2'b11;
            m_last     = m_fs;
        end
        m_sc = (m_fs != old_fs);
        // A bit flips once its last DB synchronised samples (pad delayed 2 clocks) all differ
        for (int b = 0; b < 2; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++) begin
                idx = hist.size() - 3 - k;
                v   = (idx >= 0) ? hist[idx][b] : 1'b0;
                if (v == m_ss[b]) all_diff = 1'b0;
            end
            if (all_diff) m_ss[b] = ~m_ss[b];
        end
    endtask

    task automatic step(input logic [1:0] s);
        sensor = s;
        @(posedge clk);
        model_edge();
        #1;
        chk("sensors_signal", sensors_signal, m_ss);
        chk("follower_state", follower_state, m_fs);
        chk("state_change", {1'b0, state_change}, {1'b0, m_sc});
        chk("line_lost", {1'b0, line_lost}, {1'b0, m_lost});
    endtask

    initial begin
        int v;
        int len;

        // Reset held with both sensors on the line
        rst = 1'b1;
        repeat (3) step(2'b11);
        chk("reset_outputs", {follower_state | sensors_signal}, 2'b00);
        rst = 1'b0;
        repeat (12) step(2'b00);
        chk("idle_after_reset", sensors_signal, 2'b00);

        // Glitch rejection: 3-cycle pulse on left
        repeat (3) step(2'b01);
        repeat (8) step(2'b00);
        chk("glitch_ss", sensors_signal, 2'b00);

        // Held left: accepted at cycle 6, steering at cycle 7
        repeat (5) step(2'b01);
        chk("left_pre", sensors_signal, 2'b00);
        step(2'b01);
        chk("left_ss_c6", sensors_signal, 2'b01);
        chk("left_fs_c6", follower_state, 2'b00);
        step(2'b01);
        chk("left_fs_c7", follower_state, 2'b01);
        chk("left_sc_c7", {1'b0, state_change}, 2'b01);
        step(2'b01);
        chk("left_sc_c8", {1'b0, state_change}, 2'b00);

        // Crossing hold and timeout from LEFT
        for (int i = 1; i <= 28; i++) begin
            step(2'b11);
            if (i == 26) chk("cross_hold_fs", follower_state, 2'b01);
            if (i == 27) begin
                chk("cross_lost", {1'b0, line_lost}, 2'b01);
                chk("cross_forced_rest", follower_state, 2'b00);
                chk("cross_lost_sc", {1'b0, state_change}, 2'b01);
            end
        end
        repeat (7) step(2'b01);
        chk("cross_exit_lost", {1'b0, line_lost}, 2'b00);
        chk("cross_exit_fs", follower_state, 2'b01);

        // Simultaneous change 01 -> 10
        repeat (7) step(2'b10);
        chk("simul_fs", follower_state, 2'b11);
        chk("simul_sc", {1'b0, state_change}, 2'b01);

        // Right back to rest
        repeat (7) step(2'b00);
        chk("rest_fs", follower_state, 2'b00);

        // Reset mid-debounce of the right sensor
        repeat (2) step(2'b10);
        rst = 1'b1;
        step(2'b10);
        rst = 1'b0;
        repeat (5) step(2'b10);
        chk("rst_mid_pre", sensors_signal, 2'b00);
        step(2'b10);
        chk("rst_mid_ss", sensors_signal, 2'b10);
        repeat (4) step(2'b00);

        // Randomized pad activity, including short glitches and long holds
        repeat (60) begin
            v   = $urandom_range(0, 3);
            len = $urandom_range(1, 12);
            repeat (len) step(v[1:0]);
        end
        repeat (30) step(2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
